// File: rtl/mips_prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
//   s_valid/s_data/s_ready : byte stream, one transfer per clk1 edge when valid && ready
//   mem_we/mem_addr/mem_wdata : single-word memory write port
// slave  = loader side, master = host/memory side.
interface mips_prog_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_prog_loader.sv
// Framed byte-stream program loader for the MIPS32 core.
// Frame: A5, ADDR_H, ADDR_L, CNT_H, CNT_L, 4*N data bytes (big-endian words), CHK.
// CHK is the XOR of every byte between sync and CHK. Holds the core halted while
// loading; after a verified frame releases it with cpu_pc = start address.
// Ports:
//   clk1, rst_n : clock, async active-low reset
//   bus         : byte stream in, memory write port out (slave modport)
//   cpu_halt    : 1 = core halted
//   cpu_pc      : start PC, valid while cpu_halt = 0
//   load_ok     : one-cycle pulse on a verified frame
//   load_err    : sticky checksum error, cleared by the next sync byte
module mips_prog_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  mips_prog_loader_if.slave bus,
  output logic              cpu_halt,
  output logic [ADDR_W-1:0] cpu_pc,
  output logic              load_ok,
  output logic              load_err
);

  localparam int unsigned CNT_W  = 16;
  localparam logic [7:0]  SYNC_B = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA, S_CHK, S_DONE
  } state_t;

  state_t            state;
  logic [7:0]        addr_h;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] word_addr;
  logic [CNT_W-1:0]  words_left;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_q;     // first three bytes of the word being assembled
  logic [7:0]        chk;
  logic              xfer;
  logic [CNT_W-1:0]  cnt_next;

  assign xfer     = bus.s_valid && bus.s_ready;
  assign cnt_next = {words_left[CNT_W-1:8], bus.s_data};

  // Frame parser, word assembly and all registered outputs
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.s_ready   <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_halt      <= 1'b1;
      cpu_pc        <= '0;
      load_ok       <= 1'b0;
      load_err      <= 1'b0;
      addr_h        <= '0;
      start_addr    <= '0;
      word_addr     <= '0;
      words_left    <= '0;
      byte_cnt      <= '0;
      asm_q         <= '0;
      chk           <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      load_ok    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer && bus.s_data == SYNC_B) begin
            state    <= S_ADDR_H;
            load_err <= 1'b0;
            cpu_halt <= 1'b1;
            chk      <= '0;
          end
        end
        S_ADDR_H: begin
          if (xfer) begin
            addr_h <= bus.s_data;
            chk    <= chk ^ bus.s_data;
            state  <= S_ADDR_L;
          end
        end
        S_ADDR_L: begin
          if (xfer) begin
            start_addr <= ADDR_W'({addr_h, bus.s_data});
            word_addr  <= ADDR_W'({addr_h, bus.s_data});
            chk        <= chk ^ bus.s_data;
            state      <= S_CNT_H;
          end
        end
        S_CNT_H: begin
          if (xfer) begin
            words_left <= {bus.s_data, 8'h00};
            chk        <= chk ^ bus.s_data;
            state      <= S_CNT_L;
          end
        end
        S_CNT_L: begin
          if (xfer) begin
            words_left <= cnt_next;
            byte_cnt   <= '0;
            chk        <= chk ^ bus.s_data;
            state      <= (cnt_next != '0) ? S_DATA : S_CHK;
          end
        end
        S_DATA: begin
          // Sync byte value is ordinary data here
          if (xfer) begin
            asm_q    <= {asm_q[15:0], bus.s_data};
            byte_cnt <= byte_cnt + 2'd1;
            chk      <= chk ^ bus.s_data;
            if (byte_cnt == 2'd3) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= word_addr;
              bus.mem_wdata <= {asm_q, bus.s_data};
              word_addr     <= word_addr + ADDR_W'(1);  // wraps modulo 2^ADDR_W
              words_left    <= words_left - CNT_W'(1);
              if (words_left == CNT_W'(1)) state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (xfer) begin
            if (bus.s_data == chk) begin
              state       <= S_DONE;
              bus.s_ready <= 1'b0;
              load_ok     <= 1'b1;
              cpu_halt    <= 1'b0;
              cpu_pc      <= start_addr;
            end else begin
              state    <= S_IDLE;
              load_err <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          bus.s_ready <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          bus.s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: directed frames from the test plan
// plus randomized frames with garbage and bubbles, checked against a frame-level model.
module tb_mips_prog_loader;
  localparam int unsigned ADDR_W = 10;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_halt;
  logic [ADDR_W-1:0] cpu_pc;
  logic              load_ok;
  logic              load_err;

  always #5 clk1 = ~clk1;

  mips_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .cpu_halt (cpu_halt),
    .cpu_pc   (cpu_pc),
    .load_ok  (load_ok),
    .load_err (load_err)
  );

  typedef struct {
    int               cyc;
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  wr_t         wr_q[$];
  int          ok_q[$];
  int          acc[$];      // clock edge at which each frame byte was accepted
  logic [31:0] fr_words[$];

  always @(posedge clk1) cyc <= cyc + 1;

  // Observe memory writes and load_ok pulses away from the active edge
  always @(negedge clk1) begin
    if (bus.mem_we) wr_q.push_back('{cyc, bus.mem_addr, bus.mem_wdata});
    if (load_ok) ok_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one byte after up to max_bubble idle cycles; returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b, input int max_bubble);
    int gap;
    int t;
    gap = (max_bubble > 0) ? int'($urandom_range(0, max_bubble)) : 0;
    repeat (gap) begin
      bus.s_valid = 1'b0;
      @(negedge clk1);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    t = 0;
    while (!bus.s_ready && t < 50) begin
      @(negedge clk1);
      t++;
    end
    if (t >= 50) check("ready_timeout", 64'(bus.s_ready), 64'd1);
    acc.push_back(cyc + 1);
    @(negedge clk1);
    bus.s_valid = 1'b0;
  endtask

  // Send garbage, then a frame built from fr_words, and check it against the model
  task automatic run_frame(input logic [15:0] a16, input logic bad, input int garbage, input int maxb);
    logic [7:0]        fb[$];
    logic [7:0]        x;
    logic [15:0]       n;
    logic [ADDR_W-1:0] ea;
    logic [7:0]        g;
    int                nw;
    n = 16'(fr_words.size());
    fb.push_back(8'hA5);
    fb.push_back(a16[15:8]);
    fb.push_back(a16[7:0]);
    fb.push_back(n[15:8]);
    fb.push_back(n[7:0]);
    foreach (fr_words[k]) begin
      fb.push_back(fr_words[k][31:24]);
      fb.push_back(fr_words[k][23:16]);
      fb.push_back(fr_words[k][15:8]);
      fb.push_back(fr_words[k][7:0]);
    end
    x = 8'h00;
    for (int i = 1; i < fb.size(); i++) x = x ^ fb[i];
    if (bad) x = x ^ 8'h01;
    fb.push_back(x);

    for (int i = 0; i < garbage; i++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g, maxb);
    end
    wr_q.delete();
    ok_q.delete();
    acc.delete();

    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i], maxb);
      if (i == 0) begin
        check("halt_on_sync", 64'(cpu_halt), 64'd1);
        check("err_clr_on_sync", 64'(load_err), 64'd0);
      end
    end
    // Now in the cycle right after CHK was accepted
    check("ok_pulse", 64'(load_ok), 64'(!bad));
    check("ready_in_done", 64'(bus.s_ready), 64'(bad));
    check("halt_after_chk", 64'(cpu_halt), 64'(bad));
    check("err_after_chk", 64'(load_err), 64'(bad));
    repeat (3) @(negedge clk1);

    check("num_writes", 64'(wr_q.size()), 64'(n));
    nw = (wr_q.size() < fr_words.size()) ? wr_q.size() : fr_words.size();
    for (int k = 0; k < nw; k++) begin
      ea = ADDR_W'(a16) + ADDR_W'(k);
      check("wr_addr", 64'(wr_q[k].a), 64'(ea));
      check("wr_data", 64'(wr_q[k].d), 64'(fr_words[k]));
      check("wr_cycle", 64'(wr_q[k].cyc), 64'(acc[5 + 4 * k + 3]));
    end
    check("num_ok", 64'(ok_q.size()), bad ? 64'd0 : 64'd1);
    if (!bad && ok_q.size() > 0) check("ok_cycle", 64'(ok_q[0]), 64'(acc[acc.size() - 1]));
    check("halt_final", 64'(cpu_halt), 64'(bad));
    check("err_final", 64'(load_err), 64'(bad));
    if (!bad) check("cpu_pc", 64'(cpu_pc), 64'(ADDR_W'(a16)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (2) @(negedge clk1);
    check("rst_ready", 64'(bus.s_ready), 64'd1);
    check("rst_we", 64'(bus.mem_we), 64'd0);
    check("rst_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_halt", 64'(cpu_halt), 64'd1);
    check("rst_pc", 64'(cpu_pc), 64'd0);
    check("rst_ok", 64'(load_ok), 64'd0);
    check("rst_err", 64'(load_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk1);

    // Test-plan frame, good and with corrupted CHK
    fr_words = '{32'h28010080, 32'h0C631800};
    run_frame(16'h0000, 1'b0, 0, 0);
    run_frame(16'h0000, 1'b1, 0, 0);
    // Garbage before sync plus bubbles
    fr_words = '{32'h00000064};
    run_frame(16'h0080, 1'b0, 2, 3);
    // Address wrap, and upper address bits ignored
    fr_words = '{32'hA5A5A5A5, 32'h12345678};
    run_frame(16'h03FF, 1'b0, 0, 0);
    run_frame(16'hFC12, 1'b0, 0, 1);
    // Empty frame
    fr_words.delete();
    run_frame(16'h0010, 1'b0, 0, 0);

    // Reset after the 2nd data byte of a word: no write, back to reset values
    wr_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    rst_n = 1'b0;
    @(negedge clk1);
    check("midrst_halt", 64'(cpu_halt), 64'd1);
    check("midrst_pc", 64'(cpu_pc), 64'd0);
    check("midrst_ready", 64'(bus.s_ready), 64'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk1);
    check("midrst_nowrite", 64'(wr_q.size()), 64'd0);
    check("midrst_err", 64'(load_err), 64'd0);
    fr_words = '{32'hCAFEF00D, 32'h00000001, 32'hFFFFFFFF};
    run_frame(16'h0020, 1'b0, 0, 0);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      int n;
      n = int'($urandom_range(0, 6));
      fr_words.delete();
      for (int k = 0; k < n; k++) fr_words.push_back($urandom);
      run_frame(16'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
